// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Iterative radix-2 restoring divider for the EXE stage.
//                Produces one quotient bit per cycle for DIV (signed) and
//                DIVU (unsigned). Quotient goes to LO and remainder to HI.
//                A start/done handshake is used, and the operation can be
//                flushed with cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // The iteration counter runs 0..WIDTH-1. The datapath assumes WIDTH >= 2.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_accept;
    logic              w_finish;

    // Iteration state: the dividend register shifts left, and quotient bits
    // enter at its LSB. After WIDTH steps it therefore holds the raw quotient.
    logic [WIDTH-1:0]  r_dvd;
    logic [WIDTH-1:0]  r_dsr;
    logic [WIDTH-1:0]  r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div_zero;
    logic [WIDTH-1:0]  r_orig_dvd;

    logic [WIDTH-1:0]  r_quotient;
    logic [WIDTH-1:0]  r_remainder;

    // Operand magnitudes. Two's-complement negation of the most negative
    // value gives the same bit pattern back, and that pattern is the correct
    // unsigned magnitude.
    logic [WIDTH-1:0]  w_dvd_abs;
    logic [WIDTH-1:0]  w_dsr_abs;

    // Datapath for a single restoring step.
    logic [WIDTH:0]    w_rem_sh;
    logic              w_ge;
    logic [WIDTH-1:0]  w_rem_sub;
    logic [WIDTH-1:0]  w_rem_nx;
    logic [WIDTH-1:0]  w_dvd_nx;

    assign w_dvd_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dsr_abs = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The partial remainder stays below |divisor|, so it fits in WIDTH bits.
    // Only the shifted value needs the extra bit for the compare. The
    // subtraction result is always below 2^WIDTH, so the subtraction can be
    // done at WIDTH bits.
    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dsr});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dsr;
    assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    assign w_dvd_nx  = {r_dvd[WIDTH-2:0], w_ge};

    // The final iteration completes without a flush in the same cycle.
    assign w_finish  = (r_state == ST_CALC) && !cancel && (r_cnt == c_last_iter);

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and handshake outputs. Cancel takes priority over start.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start && !cancel) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cancel) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == c_last_iter) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (cancel) begin
                    w_state_nx = ST_IDLE;
                end else if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_CALC;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one restoring iteration per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd      <= '0;
            r_dsr      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_orig_dvd <= '0;
        end else if (w_accept) begin
            r_dvd      <= w_dvd_abs;
            r_dsr      <= w_dsr_abs;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r    <= sign && dividend[WIDTH-1];
            r_div_zero <= (divisor == '0);
            r_orig_dvd <= dividend;
        end else if ((r_state == ST_CALC) && !cancel) begin
            r_dvd      <= w_dvd_nx;
            r_rem      <= w_rem_nx;
            r_cnt      <= r_cnt + c_cnt_one;
        end
    end

    // Result register: loaded only when an operation completes, so an
    // aborted operation leaves the previous result visible. Divide-by-zero
    // overrides the sign fix-up. It returns all ones and the untouched
    // dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_finish) begin
            if (r_div_zero) begin
                r_quotient  <= '1;
                r_remainder <= r_orig_dvd;
            end else begin
                r_quotient  <= r_neg_q ? -w_dvd_nx : w_dvd_nx;
                r_remainder <= r_neg_r ? -w_rem_nx : w_rem_nx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iter_divider
//  Description : Directed self-checking bench for iter_divider. It covers
//                signed and unsigned results, overflow, divide-by-zero,
//                cancel, back-to-back operation and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_divider;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic         cancel   = 1'b0;
    logic         sign     = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor  = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    iter_divider #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle, beginning at the current negedge. The task
    // returns at the negedge of cycle 1, counting the start cycle as cycle 0.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        sign     = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0BAD_F00D;
    endtask

    // Wait for done with a bounded number of cycles. Also count how many
    // cycles busy was high.
    task automatic wait_done(input int first, output int cyc, output int bcnt);
        cyc  = first;
        bcnt = 0;
        while (!done && cyc < 45) begin
            bcnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        int bcnt;
        @(negedge clk);
        start_op(s, a, b);
        wait_done(1, cyc, bcnt);
        check({tag, "_latency"}, cyc, 33);
        check({tag, "_busy_cycles"}, bcnt, 32);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 0);
        check({tag, "_ready_after"}, {31'b0, ready}, 1);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        rst = 1'b0;

        // Directed vectors with hand-computed results
        run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
        run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
        run_op("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
        run_op("divu_ovf_ops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
        run_op("divu_dz",      1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234);
        run_op("div_dz",       1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0);
        run_op("div_min_2",    1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0);
        run_op("divu_big_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0);
        run_op("divu_5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5);
        run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);

        // Start while busy is ignored
        @(negedge clk);
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        sign     = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        @(negedge clk);
        start    = 1'b0;
        wait_done(6, cyc, bcnt);
        check("busy_start_latency", cyc, 33);
        check("busy_start_quotient", quotient, 14);
        check("busy_start_remainder", remainder, 2);

        // Cancel in CALC cycle 10: no done, and the prior result is kept
        @(negedge clk);
        start_op(1'b0, 32'd50, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 0);
        check("cancel_ready", {31'b0, ready}, 1);
        dcnt = 0;
        repeat (40) begin
            dcnt += int'(done);
            @(negedge clk);
        end
        check("cancel_no_done", dcnt, 0);
        check("cancel_keep_quotient", quotient, 14);
        check("cancel_keep_remainder", remainder, 2);

        // Start and cancel in the same cycle: the start is not accepted
        start    = 1'b1;
        cancel   = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("startcancel_busy", {31'b0, busy}, 0);
        check("startcancel_ready", {31'b0, ready}, 1);
        dcnt = 0;
        repeat (40) begin
            dcnt += int'(done);
            @(negedge clk);
        end
        check("startcancel_no_done", dcnt, 0);

        // Back-to-back: op B starts in the DONE cycle of op A
        start_op(1'b0, 32'd100, 32'd7);
        wait_done(1, cyc, bcnt);
        check("b2b_a_latency", cyc, 33);
        check("b2b_a_quotient", quotient, 14);
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("b2b_done_drop", {31'b0, done}, 0);
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_hold_quotient", quotient, 14);
        wait_done(1, cyc, bcnt);
        check("b2b_b_latency", cyc, 33);
        check("b2b_b_quotient", quotient, 32'hFFFF_FFFD);
        check("b2b_b_remainder", remainder, 32'hFFFF_FFFF);

        // Cancel in DONE has priority over start
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("done_cancel_done", {31'b0, done}, 0);
        check("done_cancel_busy", {31'b0, busy}, 0);

        // Asynchronous reset in the middle of CALC
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", {31'b0, ready}, 1);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_quotient", quotient, 0);
        check("arst_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_45_6", 1'b0, 32'd45, 32'd6, 32'd7, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
